// File: rtl/fir_sequencer.sv
// fir_sequencer: Moore controller that steps the shared register-file/ALU
// datapath through coefficient loading and a 4-tap FIR computation,
//   y = F0*x0 - F1*x1 + F2*x2 - F3*x3  (result left in R0).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset (IDLE, coeff_num = 0, cvalid = 0)
//   dr         sample ready on the datapath sample bus
//   lc         coefficient coeff_num ready on the coefficient bus
//   overflow   ALU overflow for the operation issued in the current state
//   cnt_up     one-cycle pulse per accepted sample
//   modwait    busy; dr/lc are not accepted (except dr while in STORE)
//   op         datapath opcode
//   src1/src2  source register addresses
//   dest       destination register address
//   coeff_num  index of the next coefficient to load
//   err        high while in the error idle state
//
// Register map: R0 accumulator, R1..R4 taps x0..x3 (R1 newest),
// R5 sample staging, R6..R9 coefficients F0..F3, R10 product temp.
module fir_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       dr,
    input  logic       lc,
    input  logic       overflow,
    output logic       cnt_up,
    output logic       modwait,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic [1:0] coeff_num,
    output logic       err
);

    typedef enum logic [4:0] {
        IDLE, EIDLE, LOADC, WAITC, STORE, ZERO,
        SH1, SH2, SH3, SH4,
        M1, A1, M2, S2, M3, A3, M4, S4
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_COPY  = 3'b001,
        OP_LDS   = 3'b010,
        OP_LDC   = 3'b011,
        OP_MUL   = 3'b100,
        OP_ADD   = 3'b101,
        OP_SUB   = 3'b110
    } op_t;

    state_t     state_q, state_d;
    logic [1:0] coeff_q, coeff_d;
    logic       cvalid_q, cvalid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            coeff_q  <= '0;
            cvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            coeff_q  <= coeff_d;
            cvalid_q <= cvalid_d;
        end
    end

    assign coeff_num = coeff_q;

    always_comb begin
        state_d  = state_q;
        coeff_d  = coeff_q;
        cvalid_d = cvalid_q;
        cnt_up   = 1'b0;
        modwait  = 1'b0;
        op       = OP_NOP;
        src1     = '0;
        src2     = '0;
        dest     = '0;
        err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (lc)
                    state_d = LOADC;
                else if (dr)
                    state_d = cvalid_q ? STORE : EIDLE;
            end
            EIDLE: begin
                err = 1'b1;
                if (lc)
                    state_d = LOADC;
                else if (dr && cvalid_q)
                    state_d = STORE;
            end
            LOADC: begin
                op      = OP_LDC;
                dest    = 4'd6 + {2'b00, coeff_q};
                modwait = 1'b1;
                coeff_d = coeff_q + 2'd1;
                if (coeff_q == 2'd3) begin
                    state_d  = IDLE;
                    cvalid_d = 1'b1;
                end else begin
                    state_d = WAITC;
                end
            end
            WAITC: begin
                if (lc)
                    state_d = LOADC;
                else if (dr)
                    state_d = EIDLE;
            end
            STORE: begin
                op      = OP_LDS;
                dest    = 4'd5;
                cnt_up  = 1'b1;
                modwait = 1'b1;
                // dr dropping here means the request was a glitch
                state_d = dr ? ZERO : EIDLE;
            end
            ZERO: begin
                op = OP_SUB; modwait = 1'b1;
                state_d = SH1;
            end
            SH1: begin
                op = OP_COPY; src1 = 4'd3; dest = 4'd4; modwait = 1'b1;
                state_d = SH2;
            end
            SH2: begin
                op = OP_COPY; src1 = 4'd2; dest = 4'd3; modwait = 1'b1;
                state_d = SH3;
            end
            SH3: begin
                op = OP_COPY; src1 = 4'd1; dest = 4'd2; modwait = 1'b1;
                state_d = SH4;
            end
            SH4: begin
                op = OP_COPY; src1 = 4'd5; dest = 4'd1; modwait = 1'b1;
                state_d = M1;
            end
            M1: begin
                op = OP_MUL; src1 = 4'd1; src2 = 4'd6; dest = 4'd10; modwait = 1'b1;
                state_d = overflow ? EIDLE : A1;
            end
            A1: begin
                op = OP_ADD; src1 = 4'd0; src2 = 4'd10; dest = 4'd0; modwait = 1'b1;
                state_d = overflow ? EIDLE : M2;
            end
            M2: begin
                op = OP_MUL; src1 = 4'd2; src2 = 4'd7; dest = 4'd10; modwait = 1'b1;
                state_d = overflow ? EIDLE : S2;
            end
            S2: begin
                op = OP_SUB; src1 = 4'd0; src2 = 4'd10; dest = 4'd0; modwait = 1'b1;
                state_d = overflow ? EIDLE : M3;
            end
            M3: begin
                op = OP_MUL; src1 = 4'd3; src2 = 4'd8; dest = 4'd10; modwait = 1'b1;
                state_d = overflow ? EIDLE : A3;
            end
            A3: begin
                op = OP_ADD; src1 = 4'd0; src2 = 4'd10; dest = 4'd0; modwait = 1'b1;
                state_d = overflow ? EIDLE : M4;
            end
            M4: begin
                op = OP_MUL; src1 = 4'd4; src2 = 4'd9; dest = 4'd10; modwait = 1'b1;
                state_d = overflow ? EIDLE : S4;
            end
            S4: begin
                op = OP_SUB; src1 = 4'd0; src2 = 4'd10; dest = 4'd0; modwait = 1'b1;
                state_d = overflow ? EIDLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed scenarios plus randomized dr/lc/overflow traffic,
// checked every cycle against a program-table model of the sequencer.
// The compared vector is {cnt_up, modwait, op, src1, src2, dest, coeff_num, err}.
module tb_fir_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dr = 1'b0;
    logic       lc = 1'b0;
    logic       overflow = 1'b0;
    logic       cnt_up, modwait, err;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;
    logic [1:0] coeff_num;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    fir_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .dr        (dr),
        .lc        (lc),
        .overflow  (overflow),
        .cnt_up    (cnt_up),
        .modwait   (modwait),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .dest      (dest),
        .coeff_num (coeff_num),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 error idle, 2 waiting for next coefficient,
    //       3 loading a coefficient, 4 running the sample program at m_step
    int         m_mode;
    int         m_step;
    logic [1:0] m_cnum;
    logic       m_cvalid;

    // Sample program: step -> {op, src1, src2, dest}
    function automatic logic [14:0] prog(input int s);
        case (s)
            0:  return {3'd2, 4'd0, 4'd0,  4'd5};   // load sample -> R5
            1:  return {3'd6, 4'd0, 4'd0,  4'd0};   // R0 = 0
            2:  return {3'd1, 4'd3, 4'd0,  4'd4};
            3:  return {3'd1, 4'd2, 4'd0,  4'd3};
            4:  return {3'd1, 4'd1, 4'd0,  4'd2};
            5:  return {3'd1, 4'd5, 4'd0,  4'd1};
            6:  return {3'd4, 4'd1, 4'd6,  4'd10};  // F0*x0
            7:  return {3'd5, 4'd0, 4'd10, 4'd0};
            8:  return {3'd4, 4'd2, 4'd7,  4'd10};  // F1*x1
            9:  return {3'd6, 4'd0, 4'd10, 4'd0};
            10: return {3'd4, 4'd3, 4'd8,  4'd10};  // F2*x2
            11: return {3'd5, 4'd0, 4'd10, 4'd0};
            12: return {3'd4, 4'd4, 4'd9,  4'd10};  // F3*x3
            13: return {3'd6, 4'd0, 4'd10, 4'd0};
            default: return '0;
        endcase
    endfunction

    function automatic logic [19:0] model_vec();
        logic [14:0] p;
        case (m_mode)
            1: return {2'b00, 15'd0, m_cnum, 1'b1};
            3: return {2'b01, 3'd3, 4'd0, 4'd0, 4'd6 + {2'b00, m_cnum}, m_cnum, 1'b0};
            4: begin
                p = prog(m_step);
                return {(m_step == 0), 1'b1, p, m_cnum, 1'b0};
            end
            default: return {2'b00, 15'd0, m_cnum, 1'b0};
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_cnum = 2'd0; m_cvalid = 1'b0;
    endtask

    task automatic model_clock(input logic d, input logic l, input logic o);
        case (m_mode)
            0, 1, 2: begin
                if (l) m_mode = 3;
                else if (d && m_cvalid && m_mode != 2) begin m_mode = 4; m_step = 0; end
                else if (d && m_mode != 1) m_mode = 1;
            end
            3: begin
                if (m_cnum == 2'd3) begin m_mode = 0; m_cvalid = 1'b1; end
                else m_mode = 2;
                m_cnum = m_cnum + 2'd1;
            end
            default: begin
                if (m_step == 0) begin
                    if (d) m_step = 1; else m_mode = 1;
                end else if (m_step >= 6 && o) m_mode = 1;
                else if (m_step == 13) m_mode = 0;
                else m_step = m_step + 1;
            end
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] dut_vec();
        return {cnt_up, modwait, op, src1, src2, dest, coeff_num, err};
    endfunction

    // One clock: drive inputs, model the edge, compare just after it.
    task automatic run_cycle(input logic d, input logic l, input logic o, input string tag);
        dr = d; lc = l; overflow = o;
        @(posedge clk);
        model_clock(d, l, o);
        #1;
        check_eq(tag, dut_vec(), model_vec());
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 check_eq(tag, dut_vec(), 20'd0);
        @(negedge clk);
        reset = 1'b0;
        dr = 1'b0; lc = 1'b0; overflow = 1'b0;
    endtask

    task automatic load_coeffs();
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, "load_lc");
            run_cycle(1'b0, 1'b0, 1'b0, "load_gap");
            run_cycle(1'b0, 1'b0, 1'b0, "load_gap");
        end
        check_eq("load_cvalid", {19'd0, m_cvalid}, 20'd1);
    endtask

    task automatic wait_step(input int target, input string tag);
        int unsigned n = 0;
        while (!(m_mode == 4 && m_step == target) && n < 20) begin
            run_cycle(1'b0, 1'b0, 1'b0, tag);
            n++;
        end
        check_eq({tag, "_reached"}, {19'd0, (m_mode == 4 && m_step == target)}, 20'd1);
    endtask

    int unsigned mw_cnt, cu_cnt;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_eq("reset_held", dut_vec(), 20'd0);
        @(negedge clk);
        reset = 1'b0;

        // reset asserted mid-cycle, then coefficient load
        run_cycle(1'b0, 1'b0, 1'b0, "idle");
        async_reset("reset_mid");
        load_coeffs();

        // full sample: dr for 2 cycles, count modwait/cnt_up
        mw_cnt = 0; cu_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            run_cycle(i < 2, 1'b0, 1'b0, "sample");
            mw_cnt += modwait;
            cu_cnt += cnt_up;
        end
        check_eq("modwait_cycles", 20'(mw_cnt), 20'd14);
        check_eq("cnt_up_cycles", 20'(cu_cnt), 20'd1);

        // dr glitch -> EIDLE, then a proper 2-cycle dr
        run_cycle(1'b1, 1'b0, 1'b0, "glitch_store");
        run_cycle(1'b0, 1'b0, 1'b0, "glitch_eidle");
        check_eq("glitch_err", {19'd0, err}, 20'd1);
        run_cycle(1'b1, 1'b0, 1'b0, "after_glitch");
        check_eq("after_glitch_err", {19'd0, err}, 20'd0);
        run_cycle(1'b1, 1'b0, 1'b0, "after_glitch2");
        repeat (14) run_cycle(1'b0, 1'b0, 1'b0, "drain");

        // overflow during S2 (program step 9)
        run_cycle(1'b1, 1'b0, 1'b0, "ovf_dr");
        run_cycle(1'b1, 1'b0, 1'b0, "ovf_dr");
        wait_step(9, "ovf_to_s2");
        run_cycle(1'b0, 1'b0, 1'b1, "ovf_hit");
        check_eq("ovf_err_mw", {18'd0, err, modwait}, 20'd2);
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0, "ovf_after");

        // sample without coefficients
        async_reset("reset_nocoef");
        run_cycle(1'b1, 1'b0, 1'b0, "nocoef_dr");
        check_eq("nocoef_err", {19'd0, err}, 20'd1);
        run_cycle(1'b0, 1'b0, 1'b0, "nocoef_stay");

        // dr while waiting for the next coefficient
        run_cycle(1'b0, 1'b1, 1'b0, "waitc_lc");
        run_cycle(1'b0, 1'b0, 1'b0, "waitc");
        run_cycle(1'b1, 1'b0, 1'b0, "waitc_dr");
        check_eq("waitc_err", {19'd0, err}, 20'd1);

        // reset during SH3 (program step 4) clears cvalid
        async_reset("reset_pre");
        load_coeffs();
        run_cycle(1'b1, 1'b0, 1'b0, "sh3_dr");
        run_cycle(1'b1, 1'b0, 1'b0, "sh3_dr");
        wait_step(4, "to_sh3");
        async_reset("reset_sh3");
        run_cycle(1'b1, 1'b0, 1'b0, "post_reset_dr");
        check_eq("post_reset_err", {19'd0, err}, 20'd1);

        // randomized traffic, with occasional resets
        load_coeffs();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0)
                async_reset("rand_reset");
            else
                run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 15) == 0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Moore-style sequencer that drives the shared register-file/ALU datapath through a 4-tap FIR computation. It loads four coefficients on request. For every new sample it shifts the tap line and computes y = F0·x0 − F1·x1 + F2·x2 − F3·x3 into R0. It sits between the sample/coefficient front end (`dr`, `lc`) and the datapath (`op`, `src1`, `src2`, `dest`), and raises `err` on protocol violations or arithmetic overflow.

## Interface
- No parameters. Widths are fixed by the datapath: 16 registers and 3-bit opcodes.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears the coefficient-valid flag.
- `dr`  in  1  data ready; a new sample is present on the datapath sample bus.
- `lc`  in  1  load coefficient; the coefficient addressed by `coeff_num` is on the coefficient bus.
- `overflow`  in  1  ALU overflow flag for the current operation.
- `cnt_up`  out  1  one-cycle pulse per accepted sample, for the sample counter.
- `modwait`  out  1  high while busy; no `dr`/`lc` is accepted.
- `op`  out  3  datapath opcode:
  - 000 NOP
  - 001 COPY, dest ← src1
  - 010 LOAD_SAMPLE, dest ← sample bus
  - 011 LOAD_COEFF, dest ← coefficient bus
  - 100 MUL, dest ← src1·src2
  - 101 ADD, dest ← src1+src2
  - 110 SUB, dest ← src1−src2
- `src1`, `src2`, `dest`  out  4 each  register addresses.
- `coeff_num`  out  2  index of the next coefficient to load.
- `err`  out  1  high while in EIDLE.

## Operation
- Register map:
  - R0: accumulator/result.
  - R1..R4: taps x0..x3, with R1 newest.
  - R5: sample staging.
  - R6..R9: coefficients F0..F3.
  - R10: product temp.
- All datapath outputs (`cnt_up`, `modwait`, `op`, `src1`, `src2`, `dest`, `err`) are decoded from the current state only. Unlisted fields are 0. The state register is 5 bits.
- `coeff_num` is a 2-bit counter: it increments on leaving LOADC, wraps 3→0, and resets to 0.
- `cvalid` is a flag: it is set when the 4th coefficient completes and cleared by reset.
- States and outputs:
  - IDLE: all outputs 0.
  - EIDLE: `err` = 1, all other outputs 0.
  - LOADC: `op` = 011, `dest` = 6+`coeff_num`, `modwait` = 1.
  - WAITC: all outputs 0. Waits for the next `lc`.
  - STORE: `op` = 010, `dest` = 5, `cnt_up` = 1, `modwait` = 1.
  - ZERO: SUB 0,0 → 0, `modwait` = 1.
  - SH1..SH4: COPY, each with `modwait` = 1:
    - SH1: 3 → 4
    - SH2: 2 → 3
    - SH3: 1 → 2
    - SH4: 5 → 1
  - Multiply/accumulate states, each with `modwait` = 1:
    - M1: MUL 1,6 → 10
    - A1: ADD 0,10 → 0
    - M2: MUL 2,7 → 10
    - S2: SUB 0,10 → 0
    - M3: MUL 3,8 → 10
    - A3: ADD 0,10 → 0
    - M4: MUL 4,9 → 10
    - S4: SUB 0,10 → 0
- Transitions:
  - IDLE: `lc` → LOADC; else `dr` with `cvalid` → STORE; else `dr` without `cvalid` → EIDLE; else stay.
  - `lc` and `dr` asserted together in IDLE: `lc` wins.
  - LOADC → WAITC if `coeff_num` ≠ 3. LOADC → IDLE if `coeff_num` = 3; this also sets `cvalid`.
  - WAITC: `lc` → LOADC; `dr` → EIDLE; else stay.
  - EIDLE: `lc` → LOADC; `dr` with `cvalid` → STORE; else stay.
  - STORE: `dr` still high → ZERO; `dr` low (glitch) → EIDLE. No sample is processed on a glitch, and `cnt_up` has already pulsed.
  - ZERO → SH1 → SH2 → SH3 → SH4 → M1, unconditionally.
  - M1..S4: if `overflow` = 1 in the current state → EIDLE. Otherwise advance; S4 → IDLE.
- Reload: a new `lc` sequence after `cvalid` is set reloads the coefficients. `cvalid` stays set.

## Timing
- Reset, applied asynchronously at any time including mid-sequence: state = IDLE, `coeff_num` = 0, `cvalid` = 0. All outputs are 0 immediately, without waiting for a clock.
- Inputs are sampled on the rising edge. Outputs change after the edge that enters the new state, giving one cycle of input-to-response latency.
- A sample in IDLE runs STORE, ZERO, SH1–4 and 8 MAC states: `modwait` is high for exactly 14 consecutive cycles. The result is valid in R0 on the cycle after S4, with the controller back in IDLE.
- Each coefficient occupies one cycle of `modwait` (LOADC).
- `dr` and `lc` are ignored while `modwait` = 1, except `dr` in STORE.
- The minimum sample period is 15 cycles.

## Test plan
- Reset and coefficient load:
  - Stimulus: assert `reset` mid-cycle, then release; pulse `lc` 4 times, one cycle each, 3 cycles apart.
  - Required: all outputs 0 during reset. Each LOADC shows `op` = 011 with `dest` = 6, 7, 8, 9 in order. `coeff_num` reads 1, 2, 3, 0 after the respective loads. The controller ends in IDLE.
- Full sample:
  - Stimulus: after the load, hold `dr` high for 2 cycles.
  - Required: `cnt_up` high for exactly 1 cycle and `modwait` high for exactly 14. The `op`/`src1`/`src2`/`dest` sequence matches the state list exactly (e.g. M2 = 100/2/7/10, S4 = 110/0/10/0). Then IDLE.
- `dr` glitch:
  - Stimulus: `dr` high for 1 cycle only.
  - Required: STORE, then EIDLE with `err` = 1. A later 2-cycle `dr` gives STORE with `err` = 0.
- Overflow:
  - Stimulus: force `overflow` = 1 during S2.
  - Required: next state EIDLE, `err` = 1, `modwait` = 0. M3 is never entered.
- Sample without coefficients:
  - Stimulus: after reset, `dr` with no prior loads.
  - Required: EIDLE, `err` = 1.
- Mid-load `dr` and reset mid-operation:
  - Stimulus: `dr` in WAITC; separately, assert `reset` during SH3.
  - Required: `dr` in WAITC → EIDLE. Reset during SH3 → outputs 0 at once, and a following `dr` → EIDLE because `cvalid` is cleared.
